beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//   Four-beat timing generator for the multi-cycle 16-bit CPU.
//   Drives one-hot beats t1 (fetch), t2 (decode), t3 (execute/write-back), t4 (retire),
//   which are consumed by the fetch, ALU, write-back and memory stage controllers.
//   Stretches a beat while memory is busy, stops on a HALT opcode and supports single-step.
//   Counts retired instructions.
// PARAMETERS
//   HALT_OP  5'b11111  ir[15:11] value that halts the sequencer after its t4
//   CNT_W    16        width of the retired-instruction counter
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst        in   1      reset, synchronous, active-high
//   start      in   1      leave IDLE and begin fetching; ignored in every other state
//   step_mode  in   1      1 = pause in WAIT after each instruction
//   step_req   in   1      a rising edge releases one instruction from WAIT
//   mem_busy   in   1      memory not ready; stretches t1 and t3
//   ir         in   16     current instruction register; only ir[15:11] is used
//   t          out  4      one-hot beats {t4,t3,t2,t1}; 4'b0000 outside beat states
//   busy       out  1      1 in T1..T4
//   halted     out  1      1 in HALT
//   instr_cnt  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W
// BEHAVIOUR
//   States: IDLE, T1, T2, T3, T4, WAIT, HALT. All outputs are Moore outputs, decoded from
//     registered state (no combinational input-to-output path).
//   Reset: state=IDLE, t=0000, busy=0, halted=0, instr_cnt=0, step edge register=0.
//     rst overrides everything, including mid-beat and HALT; next cycle is IDLE.
//   IDLE:  start=1 -> T1 in the next cycle; otherwise stay.
//   T1:    mem_busy=1 -> stay (beat stretched); otherwise -> T2.
//   T2:    -> T3 unconditionally (one cycle).
//   T3:    mem_busy=1 -> stay; otherwise -> T4.
//   T4:    one cycle; instr_cnt += 1 on leaving T4, with wrap-around from all-ones to 0.
//          ir[15:11]==HALT_OP -> HALT (takes priority over step_mode).
//          else step_mode=1   -> WAIT.
//          else               -> T1.
//   WAIT:  step_req rising edge (registered previous value 0, current value 1) -> T1.
//          step_mode=0 -> T1, even without an edge.
//          A step_req held high on entry to WAIT does not release WAIT; a new edge is required.
//   HALT:  sticky; only rst exits. start and step_req are ignored.
//   t is exactly one-hot in T1..T4. Each beat lasts >=1 cycle; t2 and t4 last exactly 1 cycle.
//   ir must stay stable from the end of t1 through t4; the sequencer never latches ir.
//   Minimum instruction latency is 4 cycles; each mem_busy cycle during t1 or t3 adds 1.
//   The step_req edge register samples every cycle in every state, so edges outside WAIT
//     are dropped.
// STRUCTURE
//   Shared package: state encodings (3-bit), beat index constants T1_IDX..T4_IDX,
//     HALT_OP default value, opcode field slice constants (OP_HI=15, OP_LO=11).
//   Sub-module rise_detect: 1-bit registered rising-edge detector for step_req,
//     with synchronous reset.
//   Remaining logic: one next-state always block, one state/counter register block,
//     and output decode.
// TESTING
//   1 Reset, start=1, ir=16'h3000, mem_busy=0 -> t cycles 0001,0010,0100,1000 repeatedly;
//     instr_cnt=1 after first t4, 2 after second.
//   2 mem_busy=1 for 3 cycles while in T1 and 2 cycles while in T3 -> t1 lasts 4 cycles,
//     t3 lasts 3 cycles; 9-cycle instruction; instr_cnt +1.
//   3 ir[15:11]=5'b11111 at t4 -> halted=1, t=0000, busy=0 next cycle.
//     start and step_req are then ignored for 10 cycles.
//     rst -> IDLE, instr_cnt=0.
//   4 step_mode=1 -> WAIT after t4. step_req held high 5 cycles -> exactly one instruction.
//     Low, then high again -> next instruction.
//     Clearing step_mode while in WAIT -> T1 next cycle.
//   5 CNT_W=4, run 16 instructions -> instr_cnt wraps 15 -> 0.
//     rst asserted during t3 -> IDLE, t=0000 next cycle.

Source files
------------

// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the four-beat CPU timing generator: state encoding,
// beat bit positions and the opcode field that is decoded for HALT.
package beat_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_WAIT = 3'd5,
    S_HALT = 3'd6
  } state_e;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;

  localparam logic [4:0] HALT_OP_DEF = 5'b11111;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;

  // Beat vector {t4,t3,t2,t1} for a state; zero outside the beat states.
  function automatic logic [3:0] beat_of(state_e s);
    logic [3:0] b;
    b = 4'b0000;
    case (s)
      S_T1:    b[T1_IDX] = 1'b1;
      S_T2:    b[T2_IDX] = 1'b1;
      S_T3:    b[T3_IDX] = 1'b1;
      S_T4:    b[T4_IDX] = 1'b1;
      default: b = 4'b0000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Control and status bundle between the CPU control block and the beat sequencer.
// All controls are level-sampled on the rising clock edge; there is no
// valid/ready handshake, outputs are registered-state decodes.
interface beat_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             step_mode;
  logic             step_req;
  logic             mem_busy;
  logic [15:0]      ir;
  logic [3:0]       t;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, step_mode, step_req, mem_busy, ir,
    input  t, busy, halted, instr_cnt
  );

  modport slave (
    input  start, step_mode, step_req, mem_busy, ir,
    output t, busy, halted, instr_cnt
  );
endinterface

// File: rtl/beat_sequencer_rise_detect.sv
// Registered rising-edge detector: the previous value is sampled every cycle,
// so an edge is seen only in the cycle the input first goes high.
module beat_sequencer_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/beat_sequencer.sv
// Four-beat timing generator: one-hot t1..t4, memory-stretched t1/t3,
// HALT opcode stop, single-step WAIT and a retired-instruction counter.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter logic [4:0] HALT_OP = HALT_OP_DEF,
  parameter int         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  beat_sequencer_if.slave   bus,
  output state_e            o_state
);
  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_step_rise;
  logic             w_is_halt_op;
  logic             w_unused_ir;

  beat_sequencer_rise_detect u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.step_req),
    .o_rise (w_step_rise)
  );

  assign w_is_halt_op = (bus.ir[OP_HI:OP_LO] == HALT_OP);
  assign w_unused_ir  = ^bus.ir[OP_LO-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_T1;
      S_T1:   if (!bus.mem_busy) w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   if (!bus.mem_busy) w_next = S_T4;
      // HALT wins over single-step so a halted program never parks in WAIT.
      S_T4: begin
        if (w_is_halt_op)       w_next = S_HALT;
        else if (bus.step_mode) w_next = S_WAIT;
        else                    w_next = S_T1;
      end
      S_WAIT: if (w_step_rise || !bus.step_mode) w_next = S_T1;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T4) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.t         = beat_of(r_state);
  assign bus.busy      = (r_state == S_T1) || (r_state == S_T2) ||
                         (r_state == S_T3) || (r_state == S_T4);
  assign bus.halted    = (r_state == S_HALT);
  assign bus.instr_cnt = r_cnt;
  assign o_state       = r_state;
endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: a vector table for run/stretch/halt and
// hand-written sequences for single-step, counter wrap and mid-beat reset.
module tb_beat_sequencer;
  import beat_sequencer_pkg::*;

  logic clk;
  logic rst;
  state_e st16;
  state_e st4;

  beat_sequencer_if #(.CNT_W(16)) bus ();
  beat_sequencer_if #(.CNT_W(4))  bus4 ();

  assign bus4.start     = bus.start;
  assign bus4.step_mode = bus.step_mode;
  assign bus4.step_req  = bus.step_req;
  assign bus4.mem_busy  = bus.mem_busy;
  assign bus4.ir        = bus.ir;

  beat_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus), .o_state(st16));
  beat_sequencer #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4), .o_state(st4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [3:0] exp_q[$];

  typedef struct {
    logic        start;
    logic        step_mode;
    logic        step_req;
    logic        mem_busy;
    logic [15:0] ir;
    logic [3:0]  exp_t;
    logic        exp_busy;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic s, logic sm, logic sr, logic mb, logic [15:0] ir,
                              logic [3:0] t, logic b, logic h, logic [15:0] c);
    vec_t v;
    v.start = s; v.step_mode = sm; v.step_req = sr; v.mem_busy = mb; v.ir = ir;
    v.exp_t = t; v.exp_busy = b; v.exp_halted = h; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic sm, logic sr, logic mb, logic [15:0] ir);
    bus.start = s; bus.step_mode = sm; bus.step_req = sr; bus.mem_busy = mb; bus.ir = ir;
  endtask

  task automatic chk_beat(string name, state_e es, logic [3:0] et, logic eb, logic eh);
    chk({name, ".state"},  32'(st16), 32'(es));
    chk({name, ".t"},      32'(bus.t), 32'(et));
    chk({name, ".busy"},   32'(bus.busy), 32'(eb));
    chk({name, ".halted"}, 32'(bus.halted), 32'(eh));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // scoreboard for the 4-bit counter instance
  task automatic sb_check_cnt4(string name);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: expected queue empty, got %0h", name, bus4.instr_cnt);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(bus4.instr_cnt), 32'(e));
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // run, mem_busy stretching, HALT
    vecs[0]  = mk(0,0,0,0,16'h3000, 4'b0000,0,0,0);
    vecs[1]  = mk(1,0,0,0,16'h3000, 4'b0001,1,0,0);
    vecs[2]  = mk(0,0,0,0,16'h3000, 4'b0010,1,0,0);
    vecs[3]  = mk(0,0,1,0,16'h3000, 4'b0100,1,0,0);
    vecs[4]  = mk(0,0,0,0,16'h3000, 4'b1000,1,0,0);
    vecs[5]  = mk(1,0,0,0,16'h3000, 4'b0001,1,0,1);
    vecs[6]  = mk(0,0,0,0,16'h3000, 4'b0010,1,0,1);
    vecs[7]  = mk(0,0,0,1,16'h3000, 4'b0100,1,0,1);
    vecs[8]  = mk(0,0,0,0,16'h3000, 4'b1000,1,0,1);
    vecs[9]  = mk(0,0,0,1,16'h3000, 4'b0001,1,0,2);
    vecs[10] = mk(0,0,0,1,16'h3000, 4'b0001,1,0,2);
    vecs[11] = mk(0,0,0,1,16'h3000, 4'b0001,1,0,2);
    vecs[12] = mk(0,0,0,1,16'h3000, 4'b0001,1,0,2);
    vecs[13] = mk(0,0,0,0,16'h3000, 4'b0010,1,0,2);
    vecs[14] = mk(0,0,0,0,16'h3000, 4'b0100,1,0,2);
    vecs[15] = mk(0,0,0,1,16'h3000, 4'b0100,1,0,2);
    vecs[16] = mk(0,0,0,1,16'h3000, 4'b0100,1,0,2);
    vecs[17] = mk(0,0,0,0,16'h3000, 4'b1000,1,0,2);
    vecs[18] = mk(0,0,0,0,16'h3000, 4'b0001,1,0,3);
    vecs[19] = mk(0,0,0,0,16'hF800, 4'b0010,1,0,3);
    vecs[20] = mk(0,0,0,0,16'hF800, 4'b0100,1,0,3);
    vecs[21] = mk(0,0,0,0,16'hF800, 4'b1000,1,0,3);
    vecs[22] = mk(0,1,0,0,16'hF800, 4'b0000,0,1,4);

    tick();
    tick();
    chk("reset.t", 32'(bus.t), 32'h0);
    chk("reset.busy", 32'(bus.busy), 32'h0);
    chk("reset.halted", 32'(bus.halted), 32'h0);
    chk("reset.cnt", 32'(bus.instr_cnt), 32'h0);
    chk("reset.state", 32'(st16), 32'(S_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].start, vecs[i].step_mode, vecs[i].step_req, vecs[i].mem_busy, vecs[i].ir);
      tick();
      chk($sformatf("vec%0d.t", i), 32'(bus.t), 32'(vecs[i].exp_t));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d.halted", i), 32'(bus.halted), 32'(vecs[i].exp_halted));
      chk($sformatf("vec%0d.cnt", i), 32'(bus.instr_cnt), 32'(vecs[i].exp_cnt));
    end

    // HALT is sticky against start and step_req
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i[1], i[0], 1'b0, 16'h0000);
      tick();
      chk_beat($sformatf("halt%0d", i), S_HALT, 4'b0000, 1'b0, 1'b1);
      chk($sformatf("halt%0d.cnt", i), 32'(bus.instr_cnt), 32'd4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk_beat("halt_rst", S_IDLE, 4'b0000, 1'b0, 1'b0);
    chk("halt_rst.cnt", 32'(bus.instr_cnt), 32'd0);
    tick();
    chk_beat("halt_rst_idle", S_IDLE, 4'b0000, 1'b0, 1'b0);

    // single-step
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
    tick();
    chk_beat("step.t1", S_T1, 4'b0001, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick(); chk_beat("step.t2", S_T2, 4'b0010, 1'b1, 1'b0);
    tick(); chk_beat("step.t3", S_T3, 4'b0100, 1'b1, 1'b0);
    tick(); chk_beat("step.t4", S_T4, 4'b1000, 1'b1, 1'b0);
    tick(); chk_beat("step.wait", S_WAIT, 4'b0000, 1'b0, 1'b0);
    chk("step.cnt1", 32'(bus.instr_cnt), 32'd1);
    tick(); tick();
    chk_beat("step.wait_hold", S_WAIT, 4'b0000, 1'b0, 1'b0);
    bus.step_req = 1'b1;
    tick(); chk_beat("step.r_t1", S_T1, 4'b0001, 1'b1, 1'b0);
    tick(); chk_beat("step.r_t2", S_T2, 4'b0010, 1'b1, 1'b0);
    tick(); chk_beat("step.r_t3", S_T3, 4'b0100, 1'b1, 1'b0);
    tick(); chk_beat("step.r_t4", S_T4, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat($sformatf("step.held%0d", i), S_WAIT, 4'b0000, 1'b0, 1'b0);
    end
    chk("step.cnt2", 32'(bus.instr_cnt), 32'd2);
    bus.step_req = 1'b0;
    tick(); chk_beat("step.low", S_WAIT, 4'b0000, 1'b0, 1'b0);
    bus.step_req = 1'b1;
    tick(); chk_beat("step.edge2", S_T1, 4'b0001, 1'b1, 1'b0);
    bus.step_req = 1'b0;
    tick(); tick(); tick();
    chk_beat("step.edge2_t4", S_T4, 4'b1000, 1'b1, 1'b0);
    tick(); chk_beat("step.wait3", S_WAIT, 4'b0000, 1'b0, 1'b0);
    chk("step.cnt3", 32'(bus.instr_cnt), 32'd3);
    bus.step_mode = 1'b0;
    tick(); chk_beat("step.clear", S_T1, 4'b0001, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    chk_beat("step.free_run", S_T1, 4'b0001, 1'b1, 1'b0);
    chk("step.cnt4", 32'(bus.instr_cnt), 32'd4);

    // counter wrap on the 4-bit instance
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    bus.start = 1'b0;
    chk("wrap.start_t1", 32'(st4), 32'(S_T1));
    for (int k = 1; k <= 16; k++) begin
      tick(); tick(); tick(); tick();
      exp_q.push_back(4'(k % 16));
      sb_check_cnt4($sformatf("wrap.cnt4_%0d", k));
      chk($sformatf("wrap.cnt16_%0d", k), 32'(bus.instr_cnt), 32'(k));
    end

    // reset in the middle of t3
    tick(); tick();
    chk_beat("midrst.pre", S_T3, 4'b0100, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_beat("midrst", S_IDLE, 4'b0000, 1'b0, 1'b0);
    chk("midrst.t4", 32'(bus4.t), 32'h0);
    chk("midrst.cnt", 32'(bus.instr_cnt), 32'd0);
    chk("midrst.cnt4", 32'(bus4.instr_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk_beat("midrst.idle", S_IDLE, 4'b0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
